// File: rtl/hwpe_stream_arbiter_burst_pkg.sv
// ============================================================================
// Module   : hwpe_stream_package
// Brief    : Shared types for the HWPE stream burst arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hwpe_stream_package;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/hwpe_stream_arbiter_burst_rr_pick.sv
// ============================================================================
// Module   : hwpe_stream_rr_pick
// Brief    : Combinational round-robin picker; search starts after last_i.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hwpe_stream_rr_pick #(
    parameter int NB_IN = 4,
    parameter int IW    = (NB_IN > 1) ? $clog2(NB_IN) : 1
) (
    input  logic [NB_IN-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic [IW-1:0]    winner_o,
    output logic             any_req_o
);

    logic [IW-1:0] cand;
    logic          found;

    // Offsets 1..NB_IN wrap around, so last_i itself is considered last.
    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        cand     = '0;
        for (int i = 1; i <= NB_IN; i++) begin
            cand = IW'((int'(last_i) + i) % NB_IN);
            if (!found && req_i[cand]) begin
                found    = 1'b1;
                winner_o = cand;
            end
        end
        any_req_o = found;
    end

endmodule

`default_nettype wire

// File: rtl/hwpe_stream_arbiter_burst.sv
// ============================================================================
// Module   : hwpe_stream_arbiter_burst
// Brief    : Round-robin burst arbiter merging NB_IN streams onto one output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hwpe_stream_arbiter_burst
    import hwpe_stream_package::*;
#(
    parameter int NB_IN      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int BW         = $clog2(MAX_BURST + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic [BW-1:0]                burst_len_i,
    input  logic [NB_IN-1:0]             push_valid_i,
    input  logic [NB_IN*DATA_WIDTH-1:0]  push_data_i,
    input  logic [NB_IN*DATA_WIDTH/8-1:0] push_strb_i,
    output logic [NB_IN-1:0]             push_ready_o,
    output logic                         pop_valid_o,
    output logic [DATA_WIDTH-1:0]        pop_data_o,
    output logic [DATA_WIDTH/8-1:0]      pop_strb_o,
    input  logic                         pop_ready_i,
    output logic [NB_IN-1:0]             grant_o,
    output logic                         busy_o
);

    localparam int IW = (NB_IN > 1) ? $clog2(NB_IN) : 1;
    localparam int SW = DATA_WIDTH / 8;

    arb_state_t    state_q, state_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic [IW-1:0] last_q, last_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] len_q, len_d;

    logic [IW-1:0] winner;
    logic          any_req;
    logic [BW-1:0] len_sane;
    logic          handshake;

    hwpe_stream_rr_pick #(
        .NB_IN (NB_IN),
        .IW    (IW)
    ) u_rr_pick (
        .req_i     (push_valid_i),
        .last_i    (last_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    always_comb begin
        if (burst_len_i == '0) begin
            len_sane = BW'(1);
        end else if (burst_len_i > BW'(MAX_BURST)) begin
            len_sane = BW'(MAX_BURST);
        end else begin
            len_sane = burst_len_i;
        end
    end

    // Output mux and ready demux; everything is gated by the GRANT state.
    always_comb begin
        busy_o       = (state_q == ARB_GRANT);
        pop_valid_o  = 1'b0;
        pop_data_o   = '0;
        pop_strb_o   = '0;
        push_ready_o = '0;
        grant_o      = '0;
        for (int k = 0; k < NB_IN; k++) begin
            if (busy_o && (gnt_idx_q == IW'(k))) begin
                grant_o[k]      = 1'b1;
                pop_valid_o     = push_valid_i[k];
                pop_data_o      = push_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                pop_strb_o      = push_strb_i[k*SW +: SW];
                push_ready_o[k] = pop_ready_i;
            end
        end
    end

    assign handshake = pop_valid_o & pop_ready_i;

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        case (state_q)
            ARB_IDLE: begin
                if (enable_i && any_req) begin
                    state_d   = ARB_GRANT;
                    gnt_idx_d = winner;
                    last_d    = winner;
                    len_d     = len_sane;
                    cnt_d     = '0;
                end
            end
            ARB_GRANT: begin
                if (handshake) begin
                    if (cnt_q == len_q - BW'(1)) begin
                        cnt_d   = '0;
                        state_d = ARB_IDLE;
                    end else begin
                        cnt_d = cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            gnt_idx_q <= '0;
            last_q    <= IW'(NB_IN - 1);
            cnt_q     <= '0;
            len_q     <= BW'(1);
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hwpe_stream_arbiter_burst.sv
// ============================================================================
// Module   : tb_hwpe_stream_arbiter_burst
// Brief    : Randomized bench for the burst arbiter against a beat-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hwpe_stream_arbiter_burst;

    localparam int NB_IN = 4;
    localparam int DW    = 32;
    localparam int MAXB  = 16;
    localparam int BW    = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enable;
    logic [BW-1:0]         burst_len;
    logic [NB_IN-1:0]      v;
    logic [DW-1:0]         d [NB_IN];
    logic [DW/8-1:0]       s [NB_IN];
    logic [NB_IN*DW-1:0]   push_data;
    logic [NB_IN*DW/8-1:0] push_strb;
    logic [NB_IN-1:0]      push_ready;
    logic                  pop_valid;
    logic [DW-1:0]         pop_data;
    logic [DW/8-1:0]       pop_strb;
    logic                  pop_ready;
    logic [NB_IN-1:0]      grant;
    logic                  busy;

    int n_vec = 0;
    int n_err = 0;

    // Model state: granted input (-1 when idle), beats left in the burst, last winner.
    int m_gnt;
    int m_left;
    int m_last;
    logic [NB_IN-1:0] served;

    logic             e_busy;
    logic [NB_IN-1:0] e_grant;
    logic             e_valid;
    logic [NB_IN-1:0] e_pready;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NB_IN; k++) begin
            push_data[k*DW +: DW]     = d[k];
            push_strb[k*DW/8 +: DW/8] = s[k];
        end
    end

    hwpe_stream_arbiter_burst #(
        .NB_IN      (NB_IN),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAXB)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .burst_len_i  (burst_len),
        .push_valid_i (v),
        .push_data_i  (push_data),
        .push_strb_i  (push_strb),
        .push_ready_o (push_ready),
        .pop_valid_o  (pop_valid),
        .pop_data_o   (pop_data),
        .pop_strb_o   (pop_strb),
        .pop_ready_i  (pop_ready),
        .grant_o      (grant),
        .busy_o       (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        e_busy   = (m_gnt >= 0);
        e_grant  = '0;
        e_valid  = 1'b0;
        e_pready = '0;
        if (e_busy) begin
            e_grant[m_gnt]  = 1'b1;
            e_valid         = v[m_gnt];
            e_pready[m_gnt] = pop_ready;
        end
        check_eq("busy", 64'(busy), 64'(e_busy));
        check_eq("grant", 64'(grant), 64'(e_grant));
        check_eq("pop_valid", 64'(pop_valid), 64'(e_valid));
        check_eq("push_ready", 64'(push_ready), 64'(e_pready));
        if (e_valid) begin
            check_eq("pop_data", 64'(pop_data), 64'(d[m_gnt]));
            check_eq("pop_strb", 64'(pop_strb), 64'(s[m_gnt]));
        end
    endtask

    task automatic update_model();
        int len_eff;
        for (int k = 0; k < NB_IN; k++) served[k] = v[k] && e_pready[k];
        if (rst) begin
            m_gnt  = -1;
            m_left = 0;
            m_last = NB_IN - 1;
        end else if (m_gnt >= 0) begin
            if (e_valid && pop_ready) begin
                m_left--;
                if (m_left == 0) m_gnt = -1;
            end
        end else if (enable && (v != '0)) begin
            len_eff = int'(burst_len);
            if (len_eff == 0) len_eff = 1;
            if (len_eff > MAXB) len_eff = MAXB;
            for (int i = 1; i <= NB_IN; i++) begin
                if (m_gnt < 0 && v[(m_last + i) % NB_IN]) m_gnt = (m_last + i) % NB_IN;
            end
            m_last = m_gnt;
            m_left = len_eff;
        end
    endtask

    // Each producer holds its beat until it is taken, then may offer a fresh one.
    task automatic run_phase(input int n, input logic [NB_IN-1:0] mask, input int pv,
                             input int pr, input int pe, input int prst, input int len_fix);
        for (int c = 0; c < n; c++) begin
            for (int k = 0; k < NB_IN; k++) begin
                if (!(v[k] && !served[k])) begin
                    v[k]      = mask[k] && ($urandom_range(99) < pv);
                    d[k]      = $urandom;
                    s[k]      = 4'($urandom);
                    served[k] = 1'b0;
                end
            end
            pop_ready = ($urandom_range(99) < pr);
            enable    = ($urandom_range(99) < pe);
            rst       = ($urandom_range(99) < prst);
            burst_len = (len_fix < 0) ? BW'($urandom_range(31)) : BW'(len_fix);
            #1;
            compare_outputs();
            @(posedge clk);
            update_model();
            @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        burst_len = '0;
        pop_ready = 1'b0;
        v         = '0;
        served    = '0;
        for (int k = 0; k < NB_IN; k++) begin
            d[k] = '0;
            s[k] = '0;
        end
        m_gnt  = -1;
        m_left = 0;
        m_last = NB_IN - 1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        run_phase(40,  4'b0100, 100, 100, 100, 0, 4);
        run_phase(60,  4'b1111, 100, 100, 100, 0, 2);
        run_phase(80,  4'b1111, 100, 50,  100, 0, 3);
        run_phase(80,  4'b1111, 60,  90,  100, 0, 0);
        run_phase(150, 4'b1111, 80,  90,  100, 0, 31);
        run_phase(150, 4'b0011, 50,  80,  100, 0, 5);
        run_phase(200, 4'b1111, 70,  70,  60,  0, -1);
        run_phase(600, 4'b1111, 60,  70,  80,  3, -1);
        run_phase(20,  4'b1111, 100, 100, 100, 100, 4);
        run_phase(40,  4'b1111, 100, 100, 100, 0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
